// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_pkg
// Purpose  : Shared types and constants for the bypassing register file:
//            clear-sequencer state encoding, default geometry and the
//            select-width derivation used by every file of the block.
// Revision : 1.0  initial release
// ============================================================================
package rf_pkg;

  // Default datapath geometry used by the register file top.
  localparam int RF_DEFAULT_WIDTH = 16;
  localparam int RF_DEFAULT_DEPTH = 8;

  // Clear-sequencer states; explicit one-bit encoding.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

  // Select width for a given register count (DEPTH is a power of two, >= 2).
  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage : rf_pkg
`default_nettype wire

// File: rtl/register_file_bypass_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_bypass_if
// Purpose  : Bundle of the register-file select, write and read signals.
//            master = decode / datapath side, slave = register file.
// Revision : 1.0  initial release
// ============================================================================
interface register_file_bypass_if
  import rf_pkg::*;
#(
  parameter int WIDTH = RF_DEFAULT_WIDTH,
  parameter int DEPTH = RF_DEFAULT_DEPTH
) ();

  localparam int AW = rf_aw(DEPTH);

  logic [AW-1:0]    AA;
  logic [AW-1:0]    BB;
  logic             RW;
  logic [AW-1:0]    DA;
  logic [WIDTH-1:0] D_data;
  logic             clear_req;
  logic [WIDTH-1:0] A_data;
  logic [WIDTH-1:0] B_data;
  logic             busy;

  modport master (
    output AA, BB, RW, DA, D_data, clear_req,
    input  A_data, B_data, busy
  );

  modport slave (
    input  AA, BB, RW, DA, D_data, clear_req,
    output A_data, B_data, busy
  );

endinterface : register_file_bypass_if
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : rf_clear_seq
// Purpose  : Clear sequencer. After reset, or on a clear request while idle,
//            walks a pointer over every register, zeroing one per cycle.
//            busy_o is high for exactly DEPTH cycles per sequence.
// Revision : 1.0  initial release
// ============================================================================
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH = RF_DEFAULT_DEPTH,
  parameter int AW    = rf_aw(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          clear_req_i,
  output logic               busy_o,
  output logic               clr_we_o,
  output logic [AW-1:0]      clr_addr_o
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  // State and pointer registers; reset (re)starts the sweep at register 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: a request is only honoured in IDLE; the sweep ends after the last register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Outputs: every CLEAR cycle zeroes the register under the pointer.
  always_comb begin
    busy_o     = (state_q == CLEAR);
    clr_we_o   = (state_q == CLEAR);
    clr_addr_o = ptr_q;
  end

endmodule : rf_clear_seq
`default_nettype wire

// File: rtl/register_file_bypass.sv
`default_nettype none
// ============================================================================
// Module   : register_file_bypass
// Purpose  : DEPTH x WIDTH register file, two combinational read ports, one
//            synchronous write port, optional write-to-read bypass, optional
//            hardwired zero register and a sequenced clear flagged by busy.
// Revision : 1.0  initial release
// ============================================================================
module register_file_bypass
  import rf_pkg::*;
#(
  parameter int WIDTH    = RF_DEFAULT_WIDTH,
  parameter int DEPTH    = RF_DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic              clk,
  input  wire logic              reset,
  register_file_bypass_if.slave  bus
);

  localparam int AW = rf_aw(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             busy;
  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             usr_we;
  logic             dst_is_zero;

  rf_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clk         (clk),
    .reset       (reset),
    .clear_req_i (bus.clear_req),
    .busy_o      (busy),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  // A user write lands only when idle and not aimed at the hardwired zero register.
  always_comb begin
    dst_is_zero = (ZERO_REG != 0) && (bus.DA == '0);
    usr_we      = bus.RW && !busy && !dst_is_zero;
  end

  // Storage: the sequencer owns the write port while clearing; no direct reset.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (usr_we) begin
      mem_q[bus.DA] <= bus.D_data;
    end
  end

  // Read port A: zero while busy or on the zero register, else bypass or stored value.
  always_comb begin
    if (busy || ((ZERO_REG != 0) && (bus.AA == '0))) begin
      bus.A_data = '0;
    end else if ((BYPASS != 0) && usr_we && (bus.DA == bus.AA)) begin
      bus.A_data = bus.D_data;
    end else begin
      bus.A_data = mem_q[bus.AA];
    end
  end

  // Read port B: same selection rule as port A on BB.
  always_comb begin
    if (busy || ((ZERO_REG != 0) && (bus.BB == '0))) begin
      bus.B_data = '0;
    end else if ((BYPASS != 0) && usr_we && (bus.DA == bus.BB)) begin
      bus.B_data = bus.D_data;
    end else begin
      bus.B_data = mem_q[bus.BB];
    end
  end

  // Busy flag straight from the sequencer.
  always_comb begin
    bus.busy = busy;
  end

endmodule : register_file_bypass
`default_nettype wire

// File: tb/tb_register_file_bypass.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_bypass
// Purpose  : Directed self-checking bench; a bypassing and a non-bypassing
//            instance share the same stimulus.
// Revision : 1.0  initial release
// ============================================================================
module tb_register_file_bypass;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             reset;
  logic [AW-1:0]    AA, BB, DA;
  logic             RW;
  logic [WIDTH-1:0] D_data;
  logic             clear_req;

  int n_checks;
  int n_fail;

  register_file_bypass_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_byp ();
  register_file_bypass_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_nb  ();

  assign if_byp.AA = AA;  assign if_nb.AA = AA;
  assign if_byp.BB = BB;  assign if_nb.BB = BB;
  assign if_byp.RW = RW;  assign if_nb.RW = RW;
  assign if_byp.DA = DA;  assign if_nb.DA = DA;
  assign if_byp.D_data = D_data;        assign if_nb.D_data = D_data;
  assign if_byp.clear_req = clear_req;  assign if_nb.clear_req = clear_req;

  register_file_bypass #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_byp)
  );

  register_file_bypass #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(0)
  ) dut_nb (
    .clk   (clk),
    .reset (reset),
    .bus   (if_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    RW = 1'b1; DA = a; D_data = d;
    step();
    RW = 1'b0;
  endtask

  // Count cycles with busy high starting now; optional mid-sequence clear request.
  task automatic count_busy(output int n, input int req_at);
    n = 0;
    while (if_byp.busy && n < 50) begin
      n++;
      clear_req = (n == req_at);
      step();
    end
    clear_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      AA = AW'(i); BB = AW'(DEPTH - 1 - i);
      #1;
      check({tag, "_A"}, 32'(if_byp.A_data), 32'h0);
      check({tag, "_B"}, 32'(if_byp.B_data), 32'h0);
    end
  endtask

  initial begin
    int n;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; AA = '0; BB = '0; DA = '0; RW = 1'b0; D_data = '0; clear_req = 1'b0;

    step(); step();
    check("reset_busy", 32'(if_byp.busy), 32'h1);
    check("reset_A_zero", 32'(if_byp.A_data), 32'h0);

    // Release reset: busy for exactly DEPTH cycles.
    reset = 1'b0;
    count_busy(n, 0);
    check("init_busy_cycles", 32'(n), 32'd8);
    check_all_zero("init_read");

    // Basic writes and reads.
    wr(3'd3, 16'h1234);
    wr(3'd5, 16'hBEEF);
    AA = 3'd3; BB = 3'd5; #1;
    check("rd_A_r3", 32'(if_byp.A_data), 32'h1234);
    check("rd_B_r5", 32'(if_byp.B_data), 32'hBEEF);
    check("nb_rd_A_r3", 32'(if_nb.A_data), 32'h1234);
    AA = 3'd5; BB = 3'd5; #1;
    check("same_sel_A", 32'(if_byp.A_data), 32'hBEEF);
    check("same_sel_B", 32'(if_byp.B_data), 32'hBEEF);

    // Same-cycle write to R2 read on A and B.
    RW = 1'b1; DA = 3'd2; D_data = 16'h00A5; AA = 3'd2; BB = 3'd2; #1;
    check("bypass_A", 32'(if_byp.A_data), 32'h00A5);
    check("bypass_B", 32'(if_byp.B_data), 32'h00A5);
    check("nobypass_A_old", 32'(if_nb.A_data), 32'h0);
    step(); RW = 1'b0; #1;
    check("after_edge_A", 32'(if_byp.A_data), 32'h00A5);
    check("nb_after_edge_A", 32'(if_nb.A_data), 32'h00A5);

    // Zero register ignores writes and bypass.
    RW = 1'b1; DA = 3'd0; D_data = 16'hFFFF; AA = 3'd0; BB = 3'd3; #1;
    check("zero_bypass_A", 32'(if_byp.A_data), 32'h0);
    check("zero_bypass_B_r3", 32'(if_byp.B_data), 32'h1234);
    step(); RW = 1'b0; #1;
    check("zero_after_A", 32'(if_byp.A_data), 32'h0);
    check("nb_zero_after_A", 32'(if_nb.A_data), 32'h0);

    // Load R1..R7, then clear with a write in the request cycle.
    for (int i = 1; i < DEPTH; i++) wr(AW'(i), 16'(16'h1000 + i));
    AA = 3'd7; BB = 3'd1; #1;
    check("load_r7", 32'(if_byp.A_data), 32'h1007);
    check("load_r1", 32'(if_byp.B_data), 32'h1001);
    clear_req = 1'b1; RW = 1'b1; DA = 3'd6; D_data = 16'h6666;
    step();
    clear_req = 1'b0;
    check("clear_busy_rise", 32'(if_byp.busy), 32'h1);
    // Writes held during busy must be dropped; second request at cycle 3.
    RW = 1'b1; DA = 3'd4; D_data = 16'h5555;
    count_busy(n, 3);
    RW = 1'b0;
    check("clear_busy_cycles", 32'(n), 32'd8);
    check_all_zero("post_clear");
    check("nb_post_clear_busy", 32'(if_nb.busy), 32'h0);

    // Reset at clear cycle 4 restarts the sweep.
    wr(3'd7, 16'h7777);
    clear_req = 1'b1; step(); clear_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_busy(n, 0);
    check("restart_busy_cycles", 32'(n), 32'd8);
    AA = 3'd7; #1;
    check("restart_r7_zero", 32'(if_byp.A_data), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_register_file_bypass
`default_nettype wire

// File: doc/register_file_bypass.md
Name: register_file_bypass

Overview:
- Parametrised multi-register file for the datapath: two combinational read ports (A, B) and one synchronous write port.
- Adds configurable write-to-read bypass, an optional hardwired zero register, and a sequencer that clears every register after reset or on request, flagged by `busy`.
- Sits between instruction decode (register selects) and the function unit / bus muxes.

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 8, number of registers; must be a power of two, at least 2.
- AW, $clog2(DEPTH), select/address width; derived, never overridden.
- ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1 a same-cycle write to a selected register is forwarded to the read port.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- AA  in  AW  read select, port A.
- BB  in  AW  read select, port B.
- RW  in  1  register write enable.
- DA  in  AW  write destination select.
- D_data  in  WIDTH  write data.
- clear_req  in  1  request a full clear; single-cycle pulse or level.
- A_data  out  WIDTH  read data, port A.
- B_data  out  WIDTH  read data, port B.
- busy  out  1  clear sequence in progress.

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage: DEPTH x WIDTH flops. The array is not reset directly; it is zeroed by the clear sequencer.
- Reset (sampled on a clk edge):
  - state <= CLEAR, ptr <= 0, busy = 1.
  - A_data = B_data = 0 while busy.
  - Reset asserted mid-clear restarts the sequence at ptr 0.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle reg[ptr] <= 0 and ptr <= ptr+1.
  - When ptr == DEPTH-1 the last register is zeroed and the next state is IDLE.
  - busy is high exactly DEPTH cycles after reset deasserts (8 for defaults).
  - IDLE -> CLEAR on the edge where clear_req=1, with ptr <= 0; busy rises the next cycle.
  - clear_req during CLEAR is ignored; no restart, no queuing.
- Writes:
  - In IDLE, with RW=1 at the clk edge: reg[DA] <= D_data, unless ZERO_REG=1 and DA==0 (write dropped).
  - In CLEAR, RW is ignored and no user write occurs.
  - A write in the same cycle as clear_req (IDLE) completes, then is cleared by the sequence.
- Reads (combinational, zero latency):
  - A_data = reg[AA] and B_data = reg[BB].
  - Forced to 0 when busy=1, or when ZERO_REG=1 and the select == 0.
- Bypass (BYPASS=1, IDLE, RW=1, DA==AA, DA not the zero register): A_data = D_data in the same cycle. Same rule for B on BB.
- Bypass with BYPASS=0: reads return the pre-write value until the edge.
- AA == BB is legal; both ports return the same value.
- Widths:
  - D_data is stored unmodified; no sign or width conversion.
  - ptr is AW bits, wraps only by the FSM exit, never modulo.

Decomposition:
- Package rf_pkg holds:
  - the state enum (IDLE, CLEAR);
  - the shared AW derivation constant/function;
  - the default WIDTH/DEPTH constants used by the datapath top.
- One natural sub-module: rf_clear_seq. It contains the FSM and ptr, and outputs busy, clr_we and clr_addr.
- The array, write-port mux and read/bypass muxes stay in register_file_bypass.

Test Plan:
- Reset 1 cycle, then release → busy=1 for exactly 8 cycles; after that, all 8 registers read 0 on A and B.
- Write R3=0x1234 and R5=0xBEEF, then AA=3, BB=5 → A_data=0x1234, B_data=0xBEEF. AA=BB=5 → both 0xBEEF.
- RW=1, DA=2, D_data=0x00A5, AA=2 in the same cycle:
  - BYPASS=1 → A_data=0x00A5 before the edge;
  - BYPASS=0 → old value (0) until the edge, then 0x00A5.
- ZERO_REG=1: write DA=0 with 0xFFFF, AA=0, with a same-cycle bypass attempt → A_data=0 throughout and after the edge.
- R1..R7 loaded, clear_req pulse:
  - busy high the next cycle for 8 cycles;
  - RW=1 writes during busy are dropped;
  - all reads 0 afterwards;
  - a second clear_req mid-sequence does not extend busy.
- Reset asserted at clear cycle 4 → sequence restarts at ptr 0, with busy high 8 cycles from the reset release.
